rom_port_arbiter: RTL
=====================

// Module: rom_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one synchronous ROM read port between NREQ
//  requesters (sine/cosine address generators, phase-offset channels, etc.).
//  Each requester issues single-beat reads. Data is returned in order, tagged
//  by a one-hot rsp_valid. Sits between the address generators and the
//  waveform ROM, so one single-port ROM serves several wave outputs.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  ADDR_WIDTH  8   ROM address width
//  DATA_WIDTH  8   ROM data width
//  ROM_LAT     1   ROM read latency in clocks, from rom_en/rom_addr to rom_data (1..4)
// PORTS
//  clk        in   1                clock, all state on posedge
//  rst        in   1                asynchronous reset, active-high
//  req        in   NREQ             per-requester read request (level)
//  addr_in    in   NREQ*ADDR_WIDTH  packed addresses; requester i at [i*AW +: AW]
//  gnt        out  NREQ             one-hot grant, combinational this cycle
//  rom_en     out  1                ROM read enable
//  rom_addr   out  ADDR_WIDTH       ROM address
//  rom_data   in   DATA_WIDTH       ROM read data, valid ROM_LAT cycles after rom_en
//  rsp_valid  out  NREQ             one-hot, pulses when rsp_data is for requester i
//  rsp_data   out  DATA_WIDTH       response data (= rom_data)
// BEHAVIOUR
//  - Reset values: gnt=0, rom_en=0, rsp_valid=0, priority pointer ptr=0
//    (requester 0 highest), response pipeline cleared. rom_addr and rsp_data
//    are don't-care while their qualifiers are low.
//  - Arbitration (combinational): scan from ptr upward, modulo NREQ. The first
//    i with req[i]=1 wins. gnt[i]=1, rom_en=1, rom_addr=addr_in[i].
//    If no req is set: gnt=0, rom_en=0, ptr holds.
//  - Handshake: a transfer occurs when req[i]&gnt[i] is high at a clk edge.
//    The requester drops req or presents its next address on the following
//    cycle. A requester holding req with no grant keeps addr_in stable.
//  - Pointer update: on any grant to i, ptr <= (i+1) mod NREQ.
//    A continuously held req is granted within NREQ cycles (no starvation).
//  - Response: an ROM_LAT-deep shift register of the one-hot grant vector.
//    rsp_valid = stage[ROM_LAT-1]; rsp_data = rom_data (passthrough).
//    Total latency from grant cycle to rsp_valid is exactly ROM_LAT cycles.
//    One grant per cycle, so at most one rsp_valid bit is set per cycle.
//    Back-to-back grants give back-to-back responses.
//  - Single active requester: granted every cycle (100% throughput).
//  - ptr wrap: a grant to NREQ-1 sets ptr to 0.
//  - Reset mid-operation: in-flight responses are discarded (rsp_valid=0 on
//    the next cycle and after). Late rom_data is ignored.
//  - No internal back-pressure: requesters must accept rsp_valid whenever it
//    is asserted.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    adds output grant_cnt [NREQ*16], with requester i at [i*16 +: 16].
//    Each 16-bit counter increments on every grant to i and saturates at 16'hFFFF.
//    Cleared by rst.
//  ARB_STATS_EN undefined:
//    grant_cnt port and counters are absent.
//    Arbitration behaviour is identical in both builds.
// TESTING
//  1 Reset:
//    rst=1 with req=4'hF -> gnt=0, rom_en=0, rsp_valid=0.
//    After release, first grant goes to requester 0.
//  2 Single requester:
//    req=4'b0100 held 8 cycles, addr=0x10..0x17 -> gnt=4'b0100 every cycle.
//    rsp_valid=4'b0100 on cycles +1..+8 (ROM_LAT=1) with ROM[0x10..0x17].
//  3 Full contention:
//    req=4'hF held 8 cycles -> grant order 0,1,2,3,0,1,2,3.
//    rsp_valid follows the same order, delayed ROM_LAT cycles.
//  4 Pointer skip:
//    previous grant to 1, then req=4'b1001 -> grant 3, then 0.
//    Previous grant to 3, then req=4'b1001 -> grant 0, then 3.
//  5 Reset mid-flight:
//    ROM_LAT=3 build, grant issued, rst pulsed one cycle later ->
//    no rsp_valid for that grant; ptr=0.
//  6 ARB_STATS_EN:
//    70000 consecutive grants to requester 2 -> grant_cnt[2]=16'hFFFF.
//    Other counters are 0 and reset clears all counters.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin arbiter sharing one synchronous ROM read port among NREQ requesters.
// Define ARB_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module rom_port_arbiter #(
   parameter int NREQ       = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ROM_LAT    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*ADDR_WIDTH-1:0] addr_in,
   output logic [NREQ-1:0]            gnt,
   output logic                       rom_en,
   output logic [ADDR_WIDTH-1:0]      rom_addr,
   input  logic [DATA_WIDTH-1:0]      rom_data,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data
`ifdef ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]         grant_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_idx;
   logic [PW:0]     w_scan;
   logic            w_found;
   logic [NREQ-1:0] r_stage [ROM_LAT];

   // Scan from the priority pointer upward, wrapping at NREQ.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_scan  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_scan >= (PW+1)'(NREQ))
            w_scan = w_scan - (PW+1)'(NREQ);
         if (!w_found && req[w_scan[PW-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_scan[PW-1:0];
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (w_found && !rst)
         gnt[w_idx] = 1'b1;
   end

   assign rom_en   = w_found & ~rst;
   assign rom_addr = addr_in[w_idx*ADDR_WIDTH +: ADDR_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_ptr <= '0;
      else if (w_found)
         r_ptr <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
   end

   // Grant vector delayed by the ROM latency tags the returning data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ROM_LAT; k++)
            r_stage[k] <= '0;
      end else begin
         r_stage[0] <= gnt;
         for (int k = 1; k < ROM_LAT; k++)
            r_stage[k] <= r_stage[k-1];
      end
   end

   assign rsp_valid = r_stage[ROM_LAT-1];
   assign rsp_data  = rom_data;

`ifdef ARB_STATS_EN
   for (genvar g = 0; g < NREQ; g++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            r_cnt <= '0;
         else if (gnt[g] && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
      end
      assign grant_cnt[g*16 +: 16] = r_cnt;
   end
`endif

endmodule
